truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, settle cycles per input vector before F is sampled; legal range 1..15.
REQ-002 clock  input  1  sole clock; all state on rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a 16-vector sweep.
REQ-005 abort  input  1  synchronous sweep cancel.
REQ-006 F  input  1  output of the 4-input combinational circuit under control.
REQ-007 A, B, C, D  output  1 each  stimulus to the circuit; vector {A,B,C,D}, A = MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 truth_table  output  16  captured F; bit index = {A,B,C,D}.
REQ-011 ones_count  output  5  number of vectors with F = 1 (0..16).

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE: {A,B,C,D} = 0, busy = 0; start = 1 with abort = 0 -> SETTLE at next edge, truth_table and ones_count cleared, settle counter cleared, busy = 1.
REQ-014 SETTLE: vector held stable for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-015 SAMPLE (one cycle): truth_table[vector] <= F, ones_count += F; vector = 15 -> DONE, otherwise vector + 1 -> SETTLE.
REQ-016 DONE (one cycle): done = 1, busy = 0, vector returns to 0; -> IDLE.
REQ-017 Per-vector time SHALL be SETTLE_CYCLES + 1 cycles; done SHALL be high in the cycle beginning 16*(SETTLE_CYCLES+1) edges after the edge that sampled start.
REQ-018 start while busy or in DONE SHALL be ignored, with no effect on the sweep or outputs.
REQ-019 abort in SETTLE or SAMPLE -> IDLE at next edge; vector = 0; done not pulsed; truth_table and ones_count retain bits/count already captured; an abort-cycle SAMPLE capture SHALL still complete.
REQ-020 Simultaneous start and abort in IDLE: abort wins; no sweep starts.
REQ-021 truth_table and ones_count SHALL hold their values between sweeps until the next accepted start.
REQ-022 A, B, C, D SHALL be driven directly from registers (glitch-free stimulus).

Reset
REQ-023 reset_b = 0 SHALL immediately force IDLE, {A,B,C,D} = 0, busy = 0, done = 0, truth_table = 0, ones_count = 0 (and match = 0, first_fail = 0 when compiled in), regardless of clock.
REQ-024 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-025 Macro TT_COMPARE_EN defined: add input expected (16) and outputs match (1) and first_fail (4); at DONE, match = (truth_table == expected); first_fail = lowest mismatching index, 0 when matched; both held until next accepted start, cleared on start.
REQ-026 TT_COMPARE_EN undefined: expected, match, first_fail ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 F tied to D, SETTLE_CYCLES = 2, pulse start -> done 48 cycles after start edge, truth_table = 16'hAAAA, ones_count = 8.
REQ-028 F = A&B&C&D via bench model -> truth_table = 16'h8000, ones_count = 1; F tied 1 -> 16'hFFFF, ones_count = 16.
REQ-029 Abort after 3 SAMPLE cycles with F = 1 -> busy falls next edge, no done, truth_table = 16'h0007, ones_count = 3; {A,B,C,D} = 0.
REQ-030 start re-pulsed mid-sweep and start+abort together in IDLE -> sweep timing unchanged / no sweep started.
REQ-031 reset_b low mid-sweep between clock edges -> all outputs 0 immediately; new start after release yields a full correct sweep.
REQ-032 TT_COMPARE_EN, F tied to D, expected = 16'hAAAB -> match = 0, first_fail = 0; expected = 16'hAAAA -> match = 1.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: stimulus/capture bundle between a sweep controller and its user.
// Compile with TT_COMPARE_EN to add the expected/match/first_fail check signals.
interface truth_table_sequencer_if;
  logic start, abort, F, A, B, C, D, busy, done;
  logic [15:0] truth_table;
  logic [4:0] ones_count;
`ifdef TT_COMPARE_EN
  logic [15:0] expected;
  logic match;
  logic [3:0] first_fail;
  modport master (output start, abort, F, expected,
                  input A, B, C, D, busy, done, truth_table, ones_count, match, first_fail);
  modport slave (input start, abort, F, expected,
                 output A, B, C, D, busy, done, truth_table, ones_count, match, first_fail);
`else
  modport master (output start, abort, F,
                  input A, B, C, D, busy, done, truth_table, ones_count);
  modport slave (input start, abort, F,
                 output A, B, C, D, busy, done, truth_table, ones_count);
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps {A,B,C,D} over all 16 vectors and captures F into a truth table.
// Define TT_COMPARE_EN to compare the captured table against an expected one at sweep end.
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clock,
  input logic reset_b,
  truth_table_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
  state_t state;
  logic [3:0] vector, settle_cnt;
  logic busy, done;
  logic [15:0] truth_table, captured;
  logic [4:0] ones_count;
  always_comb begin
    captured = truth_table;
    captured[vector] = bus.F;
  end
`ifdef TT_COMPARE_EN
  logic match;
  logic [3:0] first_fail, low_diff;
  logic [15:0] diff;
  always_comb begin
    diff = captured ^ bus.expected;
    low_diff = '0;
    for (int i = 15; i >= 0; i--) if (diff[i]) low_diff = 4'(i);
  end
  assign bus.match = match;
  assign bus.first_fail = first_fail;
`endif
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      vector <= '0;
      settle_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      truth_table <= '0;
      ones_count <= '0;
`ifdef TT_COMPARE_EN
      match <= 1'b0;
      first_fail <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          state <= SETTLE;
          busy <= 1'b1;
          settle_cnt <= '0;
          truth_table <= '0;
          ones_count <= '0;
`ifdef TT_COMPARE_EN
          match <= 1'b0;
          first_fail <= '0;
`endif
        end
        SETTLE: if (bus.abort) begin
          state <= IDLE;
          busy <= 1'b0;
          vector <= '0;
        end else if (settle_cnt == LAST) state <= SAMPLE;
        else settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          // The capture still lands in the same cycle an abort is taken.
          truth_table <= captured;
          ones_count <= ones_count + {4'd0, bus.F};
          settle_cnt <= '0;
          if (bus.abort) begin
            state <= IDLE;
            busy <= 1'b0;
            vector <= '0;
          end else if (vector == 4'd15) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            vector <= '0;
`ifdef TT_COMPARE_EN
            match <= (captured == bus.expected);
            first_fail <= low_diff;
`endif
          end else begin
            state <= SETTLE;
            vector <= vector + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign {bus.A, bus.B, bus.C, bus.D} = vector;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.truth_table = truth_table;
  assign bus.ones_count = ones_count;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: scoreboard bench driving F from a selectable model of {A,B,C,D}.
module tb_truth_table_sequencer;
  localparam int S = 2;
  localparam int LAT = 16 * (S + 1);
  typedef struct {
    logic [15:0] tt;
    logic [4:0] ones;
  } exp_t;
  logic clock = 1'b0;
  logic reset_b = 1'b0;
  int mode = 0;
  int vectors = 0;
  int errors = 0;
  exp_t sb[$];
  logic [3:0] abcd;
  always #5 clock = ~clock;
  truth_table_sequencer_if bus ();
  truth_table_sequencer #(.SETTLE_CYCLES(S)) dut (.clock(clock), .reset_b(reset_b), .bus(bus));
  assign abcd = {bus.A, bus.B, bus.C, bus.D};
  function automatic logic model(input int m, input logic [3:0] v);
    return m == 0 ? v[0] : m == 1 ? &v : m == 2 ? 1'b1 : 1'b0;
  endfunction
  function automatic exp_t predict(input int m);
    exp_t e;
    e.tt = '0;
    for (int v = 0; v < 16; v++) e.tt[v] = model(m, 4'(v));
    e.ones = 5'($countones(e.tt));
    return e;
  endfunction
  always_comb bus.F = model(mode, abcd);
  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  task automatic check_outputs(input string name);
    exp_t e;
    e = sb.pop_front();
    vectors++;
    if (bus.truth_table !== e.tt) begin
      errors++;
      $display("FAIL %s truth_table: got %h want %h", name, bus.truth_table, e.tt);
    end
    vectors++;
    if (bus.ones_count !== e.ones) begin
      errors++;
      $display("FAIL %s ones_count: got %0d want %0d", name, bus.ones_count, e.ones);
    end
    vectors++;
    if (bus.busy !== 1'b0 || abcd !== 4'd0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b abcd=%h want busy=0 abcd=0", name, bus.busy, abcd);
    end
  endtask
  task automatic sweep(input int m, input int restart_at, input string name);
    int n;
    mode = m;
    sb.push_back(predict(m));
    pulse_start();
    n = 0;
    while (!bus.done && n <= LAT + 8) begin
      if (n % (S + 1) == 0 && n < LAT) begin
        vectors++;
        if (abcd !== 4'(n / (S + 1)) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s vector@%0d: got abcd=%h busy=%b want abcd=%h busy=1", name, n, abcd, bus.busy, 4'(n / (S + 1)));
        end
      end
      bus.start = (n == restart_at);
      @(negedge clock);
      n++;
    end
    vectors++;
    if (!bus.done || n != LAT) begin
      errors++;
      $display("FAIL %s done latency: got %0d (done=%b) want %0d", name, n, bus.done, LAT);
    end
    check_outputs(name);
    bus.start = (restart_at >= LAT);
    @(negedge clock);
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
  endtask
  task automatic test_reset();
    vectors++;
    if ({abcd, bus.busy, bus.done, bus.truth_table, bus.ones_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset: got abcd=%h busy=%b done=%b tt=%h ones=%0d want all 0", abcd, bus.busy, bus.done, bus.truth_table, bus.ones_count);
    end
  endtask
  task automatic test_sweeps();
    sweep(0, -1, "f_eq_d");
    sweep(1, -1, "f_and4");
    sweep(2, -1, "f_one");
    sweep(3, -1, "f_zero");
  endtask
  task automatic test_abort();
    bit seen_done;
    mode = 2;
    sb.push_back('{16'h0007, 5'd3});
    pulse_start();
    repeat (9) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check_outputs("abort");
    seen_done = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clock);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0 || bus.truth_table !== 16'h0007) begin
      errors++;
      $display("FAIL abort no_done: got activity=%b tt=%h want 0 0007", seen_done, bus.truth_table);
    end
  endtask
  task automatic test_back_to_back();
    bit seen_busy;
    sweep(0, 10, "restart_mid");
    sweep(1, LAT, "start_in_done");
    @(negedge clock);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    seen_busy = 1'b0;
    repeat (6) begin
      if (bus.busy) seen_busy = 1'b1;
      @(negedge clock);
    end
    vectors++;
    if (seen_busy !== 1'b0 || bus.truth_table !== 16'h8000 || bus.ones_count !== 5'd1) begin
      errors++;
      $display("FAIL start_abort_idle: got busy_seen=%b tt=%h ones=%0d want 0 8000 1", seen_busy, bus.truth_table, bus.ones_count);
    end
  endtask
  task automatic test_reset_mid();
    mode = 2;
    pulse_start();
    repeat (20) @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    test_reset();
    @(negedge clock);
    reset_b = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (bus.busy !== 1'b0 || bus.truth_table !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: got busy=%b tt=%h want 0 0000", bus.busy, bus.truth_table);
    end
    sweep(0, -1, "after_reset");
  endtask
`ifdef TT_COMPARE_EN
  task automatic test_compare();
    logic [15:0] exps[3] = '{16'hAAAB, 16'hAAAA, 16'hAAAE};
    logic [4:0] want[3] = '{5'b0_0000, 5'b1_0000, 5'b0_0010};
    for (int i = 0; i < 3; i++) begin
      bus.expected = exps[i];
      sweep(0, -1, "compare");
      vectors++;
      if ({bus.match, bus.first_fail} !== want[i]) begin
        errors++;
        $display("FAIL compare %h: got match=%b first_fail=%0d want match=%b first_fail=%0d", exps[i], bus.match, bus.first_fail, want[i][4], want[i][3:0]);
      end
    end
  endtask
`endif
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef TT_COMPARE_EN
    bus.expected = '0;
`endif
    repeat (2) @(negedge clock);
    test_reset();
    reset_b = 1'b1;
    test_sweeps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef TT_COMPARE_EN
    test_compare();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
